// File: rtl/wisc_pkg.sv
// Shared definitions for the instruction encoder slice.
//   FIFO_DEPTH_DEFAULT : default number of output buffer entries
//   WORD_W             : encoded instruction width
//   OP_*               : 5-bit opcodes, placed in word[15:11]
//   fmt_e              : encoding format selected by opcode
package wisc_pkg;

   localparam int FIFO_DEPTH_DEFAULT = 4;
   localparam int WORD_W             = 16;

   localparam logic [4:0] OP_HALT  = 5'b00000;
   localparam logic [4:0] OP_NOP   = 5'b00001;
   localparam logic [4:0] OP_SIIC  = 5'b00010;
   localparam logic [4:0] OP_RTI   = 5'b00011;
   localparam logic [4:0] OP_J     = 5'b00100;
   localparam logic [4:0] OP_JR    = 5'b00101;
   localparam logic [4:0] OP_JAL   = 5'b00110;
   localparam logic [4:0] OP_JALR  = 5'b00111;
   localparam logic [4:0] OP_ADDI  = 5'b01000;
   localparam logic [4:0] OP_SUBI  = 5'b01001;
   localparam logic [4:0] OP_XORI  = 5'b01010;
   localparam logic [4:0] OP_ANDNI = 5'b01011;
   localparam logic [4:0] OP_BEQZ  = 5'b01100;
   localparam logic [4:0] OP_BNEZ  = 5'b01101;
   localparam logic [4:0] OP_BLTZ  = 5'b01110;
   localparam logic [4:0] OP_BGEZ  = 5'b01111;
   localparam logic [4:0] OP_ST    = 5'b10000;
   localparam logic [4:0] OP_LD    = 5'b10001;
   localparam logic [4:0] OP_SLBI  = 5'b10010;
   localparam logic [4:0] OP_STU   = 5'b10011;
   localparam logic [4:0] OP_ROLI  = 5'b10100;
   localparam logic [4:0] OP_SLLI  = 5'b10101;
   localparam logic [4:0] OP_RORI  = 5'b10110;
   localparam logic [4:0] OP_SRLI  = 5'b10111;
   localparam logic [4:0] OP_LBI   = 5'b11000;
   localparam logic [4:0] OP_BTR   = 5'b11001;
   localparam logic [4:0] OP_SHIFT = 5'b11010;
   localparam logic [4:0] OP_ARITH = 5'b11011;
   localparam logic [4:0] OP_SEQ   = 5'b11100;
   localparam logic [4:0] OP_SLT   = 5'b11101;
   localparam logic [4:0] OP_SLE   = 5'b11110;
   localparam logic [4:0] OP_SCO   = 5'b11111;

   // ZERO: no operands; J: 11-bit displacement; I1S/I1Z: 5-bit imm signed/unsigned;
   // I2S/I2Z: 8-bit imm signed/unsigned; R: funct forced 00; RF: funct passed through
   typedef enum logic [2:0] {
      FMT_ZERO,
      FMT_J,
      FMT_I1S,
      FMT_I1Z,
      FMT_I2S,
      FMT_I2Z,
      FMT_R,
      FMT_RF
   } fmt_e;

endpackage

// File: rtl/instr_fifo.sv
// Synchronous FIFO holding encoded instruction words.
//   clk, rst            : clock, asynchronous active-high reset (empties the FIFO)
//   push, push_data     : write request/data, ignored when full
//   pop                 : remove head, ignored when empty
//   pop_data            : head word, forced to zero while empty
//   empty, full, count  : occupancy status
module instr_fifo #(
   parameter int DEPTH = wisc_pkg::FIFO_DEPTH_DEFAULT,
   parameter int WIDTH = wisc_pkg::WORD_W
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         push,
   input  logic [WIDTH-1:0]             push_data,
   input  logic                         pop,
   output logic [WIDTH-1:0]             pop_data,
   output logic                         empty,
   output logic                         full,
   output logic [$clog2(DEPTH+1)-1:0]   count
);

   localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CW = $clog2(DEPTH+1);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic             do_push;
   logic             do_pop;

   assign empty   = (count == '0);
   assign full    = (count == CW'(DEPTH));
   assign do_push = push & ~full;
   assign do_pop  = pop & ~empty;

   // Stale storage is never visible: the head reads as zero when nothing is queued.
   assign pop_data = empty ? '0 : mem[rd_ptr];

   always_ff @(posedge clk) begin
      if (do_push) begin
         mem[wr_ptr] <= push_data;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) begin
            wr_ptr <= (wr_ptr == AW'(DEPTH-1)) ? '0 : wr_ptr + 1'b1;
         end
         if (do_pop) begin
            rd_ptr <= (rd_ptr == AW'(DEPTH-1)) ? '0 : rd_ptr + 1'b1;
         end
         case ({do_push, do_pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

endmodule

// File: rtl/instr_encoder.sv
// Symbolic-to-binary instruction encoder with an output FIFO.
//   clk, rst                    : clock, asynchronous active-high reset
//   in_valid/in_ready           : request handshake
//   in_op, in_rs, in_rt, in_rd  : opcode and register fields
//   in_funct, in_imm            : R-format function code, immediate/displacement
//   out_valid/out_ready         : FIFO head handshake
//   out_instr, out_addr         : head word and its byte address
//   err                         : one-cycle pulse after an out-of-range request is accepted
//   done                        : HALT has been emitted and the FIFO is drained
//
// state   | meaning
// --------+-------------------------------------------------------------
// RUN     | accepting requests while the FIFO has space
// DRAIN   | HALT queued; no new requests, waiting for the FIFO to empty
// HALTED  | everything emitted; only rst leaves this state
module instr_encoder #(
   parameter int FIFO_DEPTH = wisc_pkg::FIFO_DEPTH_DEFAULT
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [4:0]  in_op,
   input  logic [2:0]  in_rs,
   input  logic [2:0]  in_rt,
   input  logic [2:0]  in_rd,
   input  logic [1:0]  in_funct,
   input  logic [15:0] in_imm,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [15:0] out_instr,
   output logic [15:0] out_addr,
   output logic        err,
   output logic        done
);

   import wisc_pkg::*;

   localparam int CW = $clog2(FIFO_DEPTH+1);

   typedef enum logic [1:0] {
      ST_RUN,
      ST_DRAIN,
      ST_HALTED
   } state_e;

   state_e          state_q;
   state_e          state_d;
   fmt_e            fmt;
   logic            imm_ok;
   logic [15:0]     word;
   logic            accept;
   logic            push;
   logic            pop;
   logic            fifo_empty;
   logic            fifo_full;
   logic [CW-1:0]   fifo_count;
   logic            err_q;
   logic [15:0]     addr_q;

   always_comb begin
      fmt = FMT_ZERO;
      case (in_op)
         OP_HALT, OP_NOP, OP_SIIC, OP_RTI:                 fmt = FMT_ZERO;
         OP_J, OP_JAL:                                     fmt = FMT_J;
         OP_BEQZ, OP_BNEZ, OP_BLTZ, OP_BGEZ,
         OP_LBI, OP_JR, OP_JALR:                           fmt = FMT_I2S;
         OP_SLBI:                                          fmt = FMT_I2Z;
         OP_ADDI, OP_SUBI, OP_ST, OP_LD, OP_STU:           fmt = FMT_I1S;
         OP_XORI, OP_ANDNI,
         OP_ROLI, OP_SLLI, OP_RORI, OP_SRLI:               fmt = FMT_I1Z;
         OP_SHIFT, OP_ARITH:                               fmt = FMT_RF;
         OP_BTR, OP_SEQ, OP_SLT, OP_SLE, OP_SCO:           fmt = FMT_R;
         default:                                          fmt = FMT_ZERO;
      endcase
   end

   // A signed field of N bits holds the value only if every bit above N-1
   // matches the field's sign bit; an unsigned field needs those bits clear.
   always_comb begin
      imm_ok = 1'b1;
      case (fmt)
         FMT_J:   imm_ok = (&in_imm[15:10]) | ~(|in_imm[15:10]);
         FMT_I2S: imm_ok = (&in_imm[15:7])  | ~(|in_imm[15:7]);
         FMT_I2Z: imm_ok = ~(|in_imm[15:8]);
         FMT_I1S: imm_ok = (&in_imm[15:4])  | ~(|in_imm[15:4]);
         FMT_I1Z: imm_ok = ~(|in_imm[15:5]);
         default: imm_ok = 1'b1;
      endcase
   end

   always_comb begin
      word = {in_op, 11'b0};
      case (fmt)
         FMT_ZERO:         word = {in_op, 11'b0};
         FMT_J:            word = {in_op, in_imm[10:0]};
         FMT_I2S, FMT_I2Z: word = {in_op, in_rs, in_imm[7:0]};
         FMT_I1S, FMT_I1Z: word = {in_op, in_rs, in_rd, in_imm[4:0]};
         FMT_RF:           word = {in_op, in_rs, in_rt, in_rd, in_funct};
         FMT_R:            word = {in_op, in_rs, in_rt, in_rd, 2'b00};
         default:          word = {in_op, 11'b0};
      endcase
   end

   // in_ready looks only at registered state, so a pop in the same cycle
   // never opens a slot for a push while full.
   assign in_ready = (state_q == ST_RUN) & ~fifo_full;
   assign accept   = in_valid & in_ready;
   assign push     = accept & imm_ok;
   assign pop      = out_valid & out_ready;

   instr_fifo #(
      .DEPTH (FIFO_DEPTH),
      .WIDTH (WORD_W)
   ) u_fifo (
      .clk       (clk),
      .rst       (rst),
      .push      (push),
      .push_data (word),
      .pop       (pop),
      .pop_data  (out_instr),
      .empty     (fifo_empty),
      .full      (fifo_full),
      .count     (fifo_count)
   );

   assign out_valid = ~fifo_empty;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= ST_RUN;
      end else begin
         state_q <= state_d;
      end
   end

   // Leaving DRAIN on the edge that pops the last word makes done visible
   // in the cycle right after that pop.
   always_comb begin
      state_d = state_q;
      done    = 1'b0;
      case (state_q)
         ST_RUN: begin
            if (push && (in_op == OP_HALT)) begin
               state_d = ST_DRAIN;
            end
         end
         ST_DRAIN: begin
            if (fifo_empty || ((fifo_count == CW'(1)) && pop)) begin
               state_d = ST_HALTED;
            end
         end
         ST_HALTED: begin
            done = 1'b1;
         end
         default: begin
            state_d = ST_RUN;
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         err_q  <= 1'b0;
         addr_q <= 16'h0000;
      end else begin
         err_q <= accept & ~imm_ok;
         if (pop) begin
            addr_q <= addr_q + 16'd2;
         end
      end
   end

   assign err      = err_q;
   assign out_addr = addr_q;

endmodule

// File: tb/tb_instr_encoder.sv
module tb_instr_encoder;

   logic        clk = 1'b0;
   logic        rst;
   logic        in_valid;
   logic        in_ready;
   logic [4:0]  in_op;
   logic [2:0]  in_rs;
   logic [2:0]  in_rt;
   logic [2:0]  in_rd;
   logic [1:0]  in_funct;
   logic [15:0] in_imm;
   logic        out_valid;
   logic        out_ready;
   logic [15:0] out_instr;
   logic [15:0] out_addr;
   logic        err;
   logic        done;

   instr_encoder #(.FIFO_DEPTH(4)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_op     (in_op),
      .in_rs     (in_rs),
      .in_rt     (in_rt),
      .in_rd     (in_rd),
      .in_funct  (in_funct),
      .in_imm    (in_imm),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_instr (out_instr),
      .out_addr  (out_addr),
      .err       (err),
      .done      (done)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [4:0]  op;
      logic [2:0]  rs;
      logic [2:0]  rt;
      logic [2:0]  rd;
      logic [1:0]  funct;
      logic [15:0] imm;
      logic        legal;
      logic [15:0] word;
   } vec_t;

   vec_t        vecs[$];
   logic [15:0] sb[$];
   int          checks = 0;
   int          errors = 0;
   logic [15:0] exp_addr = 16'h0000;
   logic        err_exp = 1'b0;
   logic        drv_legal = 1'b0;
   logic [15:0] drv_word = 16'h0000;

   task automatic chk(input string name, input logic [15:0] act, input logic [15:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s actual=%h required=%h", name, act, req);
      end
   endtask

   function automatic vec_t mk(input logic [4:0] op, input logic [2:0] rs, input logic [2:0] rt,
                               input logic [2:0] rd, input logic [1:0] funct, input logic [15:0] imm,
                               input logic legal, input logic [15:0] word);
      vec_t v;
      v.op = op; v.rs = rs; v.rt = rt; v.rd = rd; v.funct = funct;
      v.imm = imm; v.legal = legal; v.word = word;
      return v;
   endfunction

   // Scoreboard: acceptances push the model word, pops compare head and address.
   always @(negedge clk) begin
      logic [15:0] w;
      if (rst) begin
         err_exp = 1'b0;
      end else begin
         chk("err", 16'(err), 16'(err_exp));
         if (out_valid && out_ready) begin
            if (sb.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL unexpected_pop actual=%h required=no_word", out_instr);
            end else begin
               w = sb.pop_front();
               chk("out_instr", out_instr, w);
               chk("out_addr", out_addr, exp_addr);
            end
            exp_addr = exp_addr + 16'd2;
         end
         if (in_valid && in_ready && drv_legal) sb.push_back(drv_word);
         err_exp = in_valid & in_ready & ~drv_legal;
      end
   end

   // Called and returns at posedge+1; holds the request until it is accepted.
   task automatic send(input vec_t v);
      int n;
      bit got;
      in_op = v.op; in_rs = v.rs; in_rt = v.rt; in_rd = v.rd;
      in_funct = v.funct; in_imm = v.imm;
      drv_legal = v.legal; drv_word = v.word;
      in_valid = 1'b1;
      n = 0;
      got = 1'b0;
      while (!got && n < 200) begin
         @(negedge clk);
         if (in_ready) got = 1'b1;
         @(posedge clk);
         #1;
         n++;
      end
      in_valid = 1'b0;
      if (!got) begin
         checks++;
         errors++;
         $display("FAIL accept_timeout actual=not_accepted required=accepted op=%b", v.op);
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog actual=running required=finished");
      $fatal(1, "watchdog");
   end

   initial begin
      int acc;
      int n;
      rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
      in_op = '0; in_rs = '0; in_rt = '0; in_rd = '0; in_funct = '0; in_imm = '0;

      vecs.push_back(mk(5'b11011, 3'd3, 3'd4, 3'd5, 2'd0, 16'h7FFF, 1'b1, 16'hDB94)); // 0 ADD
      vecs.push_back(mk(5'b00100, 3'd0, 3'd0, 3'd0, 2'd0, 16'hFFFF, 1'b1, 16'h27FF)); // 1 J -1
      vecs.push_back(mk(5'b01000, 3'd1, 3'd0, 3'd2, 2'd0, 16'h0010, 1'b0, 16'h0000)); // 2 ADDI 16
      vecs.push_back(mk(5'b01000, 3'd1, 3'd0, 3'd2, 2'd0, 16'hFFFD, 1'b1, 16'h415D)); // 3 ADDI -3
      vecs.push_back(mk(5'b10010, 3'd5, 3'd0, 3'd0, 2'd0, 16'h00FF, 1'b1, 16'h95FF)); // 4 SLBI 255
      vecs.push_back(mk(5'b10010, 3'd5, 3'd0, 3'd0, 2'd0, 16'h0100, 1'b0, 16'h0000)); // SLBI 256
      vecs.push_back(mk(5'b10010, 3'd5, 3'd0, 3'd0, 2'd0, 16'hFFFF, 1'b0, 16'h0000)); // SLBI -1
      vecs.push_back(mk(5'b00100, 3'd0, 3'd0, 3'd0, 2'd0, 16'h03FF, 1'b1, 16'h23FF)); // J 1023
      vecs.push_back(mk(5'b00110, 3'd0, 3'd0, 3'd0, 2'd0, 16'hFC00, 1'b1, 16'h3400)); // JAL -1024
      vecs.push_back(mk(5'b00100, 3'd0, 3'd0, 3'd0, 2'd0, 16'h0400, 1'b0, 16'h0000)); // J 1024
      vecs.push_back(mk(5'b00101, 3'd7, 3'd0, 3'd0, 2'd0, 16'hFF80, 1'b1, 16'h2F80)); // JR -128
      vecs.push_back(mk(5'b01100, 3'd2, 3'd0, 3'd0, 2'd0, 16'h007F, 1'b1, 16'h627F)); // BEQZ 127
      vecs.push_back(mk(5'b01101, 3'd2, 3'd0, 3'd0, 2'd0, 16'h0080, 1'b0, 16'h0000)); // BNEZ 128
      vecs.push_back(mk(5'b01001, 3'd6, 3'd0, 3'd3, 2'd0, 16'hFFF0, 1'b1, 16'h4E70)); // SUBI -16
      vecs.push_back(mk(5'b10001, 3'd6, 3'd0, 3'd3, 2'd0, 16'hFFEF, 1'b0, 16'h0000)); // LD -17
      vecs.push_back(mk(5'b01010, 3'd4, 3'd0, 3'd1, 2'd0, 16'h001F, 1'b1, 16'h543F)); // XORI 31
      vecs.push_back(mk(5'b10101, 3'd4, 3'd0, 3'd1, 2'd0, 16'h0020, 1'b0, 16'h0000)); // SLLI 32
      vecs.push_back(mk(5'b01011, 3'd4, 3'd0, 3'd1, 2'd0, 16'hFFFF, 1'b0, 16'h0000)); // ANDNI -1
      vecs.push_back(mk(5'b11001, 3'd1, 3'd2, 3'd3, 2'd3, 16'h0000, 1'b1, 16'hC94C)); // BTR
      vecs.push_back(mk(5'b11010, 3'd7, 3'd0, 3'd6, 2'd2, 16'h0000, 1'b1, 16'hD71A)); // shift grp
      vecs.push_back(mk(5'b00011, 3'd7, 3'd7, 3'd7, 2'd3, 16'h1234, 1'b1, 16'h1800)); // RTI
      vecs.push_back(mk(5'b11111, 3'd0, 3'd7, 3'd7, 2'd1, 16'h0000, 1'b1, 16'hF8FC)); // SCO
      vecs.push_back(mk(5'b11000, 3'd3, 3'd0, 3'd0, 2'd0, 16'hFFFF, 1'b1, 16'hC3FF)); // LBI -1
      vecs.push_back(mk(5'b10100, 3'd0, 3'd0, 3'd7, 2'd0, 16'h0000, 1'b1, 16'hA0E0)); // ROLI 0
      vecs.push_back(mk(5'b00111, 3'd1, 3'd0, 3'd0, 2'd0, 16'h0005, 1'b1, 16'h3905)); // JALR 5
      vecs.push_back(mk(5'b10011, 3'd2, 3'd0, 3'd2, 2'd0, 16'h000F, 1'b1, 16'h9A4F)); // STU 15

      // Reset values
      repeat (2) @(posedge clk);
      #1;
      chk("rst_out_valid", 16'(out_valid), 16'h0);
      chk("rst_out_addr", out_addr, 16'h0000);
      chk("rst_err", 16'(err), 16'h0);
      chk("rst_done", 16'(done), 16'h0);
      chk("rst_out_instr", out_instr, 16'h0000);
      rst = 1'b0;
      @(posedge clk);
      #1;
      chk("run_in_ready", 16'(in_ready), 16'h1);

      // Latency 1 from accept to head
      out_ready = 1'b0;
      send(vecs[3]);
      chk("lat_out_valid", 16'(out_valid), 16'h1);
      chk("lat_out_instr", out_instr, 16'h415D);
      chk("lat_out_addr", out_addr, 16'h0000);
      out_ready = 1'b1;
      @(posedge clk);
      #1;

      // Table of formats and immediate boundaries
      foreach (vecs[i]) send(vecs[i]);
      repeat (3) @(posedge clk);
      #1;
      chk("table_drained", 16'(sb.size()), 16'h0);

      // Ordering with a full FIFO of distinct words
      out_ready = 1'b0;
      send(vecs[0]); send(vecs[1]); send(vecs[4]); send(vecs[7]);
      chk("full_in_ready", 16'(in_ready), 16'h0);
      out_ready = 1'b1;
      repeat (6) @(posedge clk);
      #1;
      chk("order_drained", 16'(sb.size()), 16'h0);

      // Five NOPs against a stalled consumer
      out_ready = 1'b0;
      in_op = 5'b00001; in_rs = '0; in_rt = '0; in_rd = '0; in_funct = '0; in_imm = '0;
      drv_word = 16'h0800; drv_legal = 1'b1;
      in_valid = 1'b1;
      acc = 0;
      repeat (6) begin
         @(negedge clk);
         if (in_ready) acc++;
         @(posedge clk);
         #1;
      end
      chk("hold_accepted", 16'(acc), 16'd4);
      chk("hold_in_ready", 16'(in_ready), 16'h0);
      chk("hold_head", out_instr, 16'h0800);
      out_ready = 1'b1;
      @(negedge clk);
      chk("no_bypass", 16'(in_ready), 16'h0);
      @(posedge clk);
      #1;
      n = 0;
      while (acc < 5 && n < 20) begin
         @(negedge clk);
         if (in_ready) acc++;
         @(posedge clk);
         #1;
         n++;
      end
      in_valid = 1'b0;
      chk("hold_fifth", 16'(acc), 16'd5);
      repeat (8) @(posedge clk);
      #1;
      chk("hold_drained", 16'(sb.size()), 16'h0);
      chk("hold_out_valid", 16'(out_valid), 16'h0);

      // Reset with words queued, asserted between edges
      out_ready = 1'b0;
      send(vecs[0]); send(vecs[1]); send(vecs[3]);
      #2;
      rst = 1'b1;
      #1;
      chk("midrst_out_valid", 16'(out_valid), 16'h0);
      chk("midrst_out_addr", out_addr, 16'h0000);
      chk("midrst_out_instr", out_instr, 16'h0000);
      sb.delete();
      exp_addr = 16'h0000;
      @(posedge clk);
      #1;
      rst = 1'b0;
      chk("midrst_in_ready", 16'(in_ready), 16'h1);
      chk("midrst_done", 16'(done), 16'h0);
      out_ready = 1'b1;
      send(vecs[1]);
      repeat (3) @(posedge clk);
      #1;
      chk("midrst_drained", 16'(sb.size()), 16'h0);

      // HALT drains and parks
      out_ready = 1'b0;
      send(mk(5'b00000, 3'd0, 3'd0, 3'd0, 2'd0, 16'h0000, 1'b1, 16'h0000));
      chk("drain_in_ready", 16'(in_ready), 16'h0);
      chk("drain_done", 16'(done), 16'h0);
      chk("drain_out_valid", 16'(out_valid), 16'h1);
      in_op = 5'b00001; drv_word = 16'h0800; drv_legal = 1'b1;
      in_valid = 1'b1;
      out_ready = 1'b1;
      @(posedge clk);
      #1;
      chk("halt_done", 16'(done), 16'h1);
      chk("halt_out_valid", 16'(out_valid), 16'h0);
      chk("halt_in_ready", 16'(in_ready), 16'h0);
      repeat (5) @(posedge clk);
      #1;
      chk("halt_done_held", 16'(done), 16'h1);
      chk("halt_out_valid_held", 16'(out_valid), 16'h0);
      in_valid = 1'b0;
      chk("halt_sb_empty", 16'(sb.size()), 16'h0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
